// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
package store_buffer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // sb keeps only the low byte of the store data
  localparam logic [DATA_W-1:0] SB_MASK = 32'h0000_00FF;

  typedef struct packed {
    logic              is_byte;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/store_fifo_mem.sv
// Store entry array: write port at tail, read port at head, and a
// per-entry word-address compare against the current load address.
module store_fifo_mem
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  wptr,
  input  sb_entry_t         wentry,
  input  logic [PTR_W-1:0]  rptr,
  output sb_entry_t         rentry,
  input  logic [ADDR_W-3:0] cmp_word,
  output logic [DEPTH-1:0]  hit
);

  sb_entry_t mem [DEPTH];

  // Entry write; contents need no reset, liveness comes from the pointers
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wentry;
  end

  // Head entry read
  always_comb begin
    rentry = mem[rptr];
  end

  // Word-address match of every entry, live or not
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit[i] = (mem[i].addr[ADDR_W-1:2] == cmp_word);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue between the MEM stage and the data memory port.
// Loads win the port; stores drain one per cycle otherwise.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic             st_byte,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  output logic             dm_we,
  output logic             dm_sb,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [31:0]      dm_pc,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;
  logic             push;
  logic             pop;
  logic             ld_grant;
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] live;
  sb_entry_t        wentry;
  sb_entry_t        rentry;

  store_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk      (clk),
    .we       (push),
    .wptr     (tail),
    .wentry   (wentry),
    .rptr     (head),
    .rentry   (rentry),
    .cmp_word (ld_addr[31:2]),
    .hit      (hit)
  );

  // Entry formatting: sb is zero-extended from its low byte
  always_comb begin
    wentry.is_byte = st_byte;
    wentry.addr    = st_addr;
    wentry.data    = st_byte ? (st_data & SB_MASK) : st_data;
    wentry.pc      = st_pc;
  end

  // Live entries are those whose distance from head is below count
  always_comb begin
    live = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live[i] = ({1'b0, PTR_W'(i) - head} < cnt);
    end
  end

  // Stall, arbitration and handshake; stalled loads yield the port to drain
  always_comb begin
    st_ready = (cnt != (PTR_W+1)'(DEPTH));
    empty    = (cnt == '0);
    count    = cnt;
    ld_stall = ld_valid && |(hit & live);
    ld_grant = ld_valid && !ld_stall;
    push     = st_valid && st_ready;
    pop      = !reset && !ld_grant && (cnt != '0);
    dm_we    = pop;
    dm_sb    = pop && rentry.is_byte;
    dm_addr  = pop ? rentry.addr : ld_addr;
    dm_wdata = rentry.data;
    dm_pc    = rentry.pc;
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores push expected writes,
// a negedge monitor pops and compares every memory write.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready, st_byte;
  logic [31:0] st_addr, st_data, st_pc;
  logic        ld_valid, ld_stall;
  logic [31:0] ld_addr;
  logic        dm_we, dm_sb;
  logic [31:0] dm_addr, dm_wdata, dm_pc;
  logic        empty;
  logic [2:0]  count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic        sb;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img [4];

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_byte(st_byte),
    .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .dm_we(dm_we), .dm_sb(dm_sb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (!reset && dm_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: act=addr 0x%08h data 0x%08h req=none", dm_addr, dm_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (dm_sb !== e.sb || dm_addr !== e.addr || dm_wdata !== e.data || dm_pc !== e.pc) begin
          bad++;
          $display("FAIL write: act=sb%0b a=%08h d=%08h pc=%08h req=sb%0b a=%08h d=%08h pc=%08h",
                   dm_sb, dm_addr, dm_wdata, dm_pc, e.sb, e.addr, e.data, e.pc);
        end
      end
      if (dm_addr[31:4] == 28'h000_0008) begin
        if (dm_sb) img[dm_addr[3:2]][8*dm_addr[1:0] +: 8] <= dm_wdata[7:0];
        else       img[dm_addr[3:2]] <= dm_wdata;
      end
    end
  end

  // Present a store (called #1 after a posedge); returns #1 after acceptance
  task automatic do_store(input logic b, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] pc);
    int unsigned n;
    wr_t e;
    st_valid = 1'b1; st_byte = b; st_addr = a; st_data = d; st_pc = pc;
    n = 0;
    while (!st_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!st_ready) begin
      total++; bad++;
      $display("FAIL store_accept_timeout: act=st_ready 0 req=1");
    end else begin
      e.sb = b; e.addr = a; e.pc = pc;
      e.data = b ? {24'h0, d[7:0]} : d;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
    end
    st_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((count != 0 || exp_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", {31'h0, (count == 0 && exp_q.size() == 0)}, 32'h1);
  endtask

  logic        v_b   [10] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 0};
  logic [31:0] v_a   [10] = '{32'h80, 32'h84, 32'h81, 32'h88, 32'h8F,
                              32'h84, 32'h8C, 32'h8E, 32'h8A, 32'h80};
  logic [31:0] v_d   [10] = '{32'h1111_1111, 32'h2222_2222, 32'h9988_77AA, 32'h3333_3333,
                              32'h0000_00BB, 32'hFFFF_FFCC, 32'h4444_4444, 32'h1234_56DD,
                              32'h0000_00EE, 32'h5555_5555};
  logic        v_gap [10] = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 0};

  initial begin
    for (int i = 0; i < 4; i++) img[i] = '0;
    reset = 1'b1; st_valid = 0; st_byte = 0; st_addr = 0; st_data = 0; st_pc = 0;
    ld_valid = 0; ld_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("dm_we_in_reset", {31'h0, dm_we}, 32'h0);
    reset = 1'b0;
    chk("reset_empty", {31'h0, empty}, 32'h1);
    chk("reset_ready", {31'h0, st_ready}, 32'h1);
    chk("reset_count", {29'h0, count}, 32'h0);

    // single sw: visible on the port the cycle after acceptance
    do_store(1'b0, 32'h10, 32'hDEAD_BEEF, 32'h3000);
    chk("t1_we", {31'h0, dm_we}, 32'h1);
    chk("t1_sb", {31'h0, dm_sb}, 32'h0);
    chk("t1_addr", dm_addr, 32'h10);
    chk("t1_wdata", dm_wdata, 32'hDEAD_BEEF);
    chk("t1_pc", dm_pc, 32'h3000);
    @(posedge clk); #1;
    chk("t1_empty", {31'h0, empty}, 32'h1);

    // fill while an unrelated load holds the port
    ld_valid = 1'b1; ld_addr = 32'h200;
    for (int k = 0; k < 4; k++)
      do_store(1'b0, 32'h40 + 32'(4*k), 32'hA000_0000 + 32'(k), 32'h3100 + 32'(4*k));
    chk("t2_full_ready", {31'h0, st_ready}, 32'h0);
    chk("t2_full_count", {29'h0, count}, 32'h4);
    chk("t2_load_addr", dm_addr, 32'h200);
    chk("t2_load_we", {31'h0, dm_we}, 32'h0);
    ld_valid = 1'b0;
    @(posedge clk); #1;
    chk("t2_ready_after_pop", {31'h0, st_ready}, 32'h1);
    chk("t2_count_after_pop", {29'h0, count}, 32'h3);
    do_store(1'b0, 32'h50, 32'hA000_0004, 32'h3110);
    chk("t2_count_push_pop", {29'h0, count}, 32'h3);
    wait_drain();

    // sb zero-extends the low byte and keeps the address
    do_store(1'b1, 32'h13, 32'h1234_56AB, 32'h3200);
    chk("t3_sb", {31'h0, dm_sb}, 32'h1);
    chk("t3_wdata", dm_wdata, 32'h0000_00AB);
    chk("t3_addr", dm_addr, 32'h13);
    wait_drain();

    // load hitting a pending store stalls until the store drains
    do_store(1'b0, 32'h20, 32'h55AA_55AA, 32'h3300);
    ld_valid = 1'b1; ld_addr = 32'h22;
    #1;
    chk("t4_stall", {31'h0, ld_stall}, 32'h1);
    chk("t4_drain_we", {31'h0, dm_we}, 32'h1);
    @(posedge clk); #1;
    chk("t4_unstall", {31'h0, ld_stall}, 32'h0);
    chk("t4_ld_addr", dm_addr, 32'h22);
    chk("t4_ld_we", {31'h0, dm_we}, 32'h0);
    ld_valid = 1'b0;

    // reset mid-drain discards the remaining entries
    ld_valid = 1'b1; ld_addr = 32'h300;
    for (int k = 0; k < 3; k++)
      do_store(1'b0, 32'h60 + 32'(4*k), 32'hB000_0000 + 32'(k), 32'h3400 + 32'(4*k));
    chk("t5_count", {29'h0, count}, 32'h3);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    ld_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t5_we_in_reset", {31'h0, dm_we}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_count", {29'h0, count}, 32'h0);
    chk("t5_empty", {31'h0, empty}, 32'h1);
    chk("t5_we", {31'h0, dm_we}, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_pending", 32'(exp_q.size()), 32'h0);

    // mixed sw/sb with load gaps; pointers wrap more than once
    for (int i = 0; i < 10; i++) begin
      if (v_gap[i]) begin
        ld_valid = 1'b1; ld_addr = 32'h84;
        @(posedge clk); #1;
        ld_valid = 1'b0;
      end
      do_store(v_b[i], v_a[i], v_d[i], 32'h3500 + 32'(4*i));
    end
    wait_drain();
    @(posedge clk); #1;
    chk("img_w0", img[0], 32'h5555_5555);
    chk("img_w1", img[1], 32'h2222_22CC);
    chk("img_w2", img[2], 32'h33EE_3333);
    chk("img_w3", img[3], 32'h44DD_4444);
    chk("final_empty", {31'h0, empty}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
